// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, mul/div op codes and sequencer state encodings
//
// Contents:
//   ALU_ADD / ALU_SUB / ALU_SLTU : ALUctr codes understood by the shared 32-bit ALU
//   md_op_e                      : MUL / DIVU / REMU request codes (2'b11 reserved, runs as MUL)
//   md_state_e                   : IDLE / RUN / FIN states of alu_muldiv_seq
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1010;

   typedef enum logic [1:0] {
      MD_MUL  = 2'b00,
      MD_DIVU = 2'b01,
      MD_REMU = 2'b10,
      MD_RSVD = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle MUL/DIVU/REMU sequencer driving the shared 32-bit ALU
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start, op         : request and op code (00 MUL, 01 DIVU, 10 REMU, 11 as MUL); sampled in IDLE only
//   src_a, src_b      : multiplicand/dividend and multiplier/divisor, captured on accept
//   busy              : high while iterating (RUN)
//   done              : one-cycle pulse in FIN; result valid in that cycle
//   result            : final value, held until the next accepted start
//   alu_a, alu_b      : ALU operands (0 outside RUN)
//   alu_ctr           : ALU control (ADD for MUL, SUB for DIV/REM; ADD outside RUN)
//   alu_res, alu_less : ALU result and unsigned-borrow flag
//
// Build option: MULDIV_EARLY_OUT_EN - MUL finishes as soon as the remaining multiplier is zero.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [XLEN-1:0]   src_a,
   input  logic [XLEN-1:0]   src_b,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [3:0]        alu_ctr,
   input  logic [XLEN-1:0]   alu_res,
   input  logic              alu_less
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             is_div_q;   // DIVU or REMU in flight
   logic             is_rem_q;   // REMU in flight
   // acc_q: MUL accumulator / DIV partial remainder
   // sh_q : MUL multiplicand (shifts left) / DIV dividend-then-quotient (shifts left)
   // opb_q: MUL multiplier (shifts right) / DIV divisor (constant)
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  sh_q, sh_d;
   logic [XLEN-1:0]  opb_q, opb_d;
   logic [XLEN-1:0]  result_q, result_d;

   logic             accept;
   logic             op_div, op_rem, op_mul;
   logic [XLEN-1:0]  rem_sh;
   logic             take;
   logic             last_iter;
   logic             run_exit;

   assign accept    = (state_q == IDLE) && start;
   assign op_div    = (op == MD_DIVU) || (op == MD_REMU);
   assign op_rem    = (op == MD_REMU);
   assign op_mul    = !op_div;
   assign rem_sh    = {acc_q[XLEN-2:0], sh_q[XLEN-1]};
   assign last_iter = (cnt_q == CNT_W'(XLEN-1));
   // The bit shifted out of acc_q is the 33rd bit of the shifted remainder; when
   // set, the true value exceeds any 32-bit divisor, so the subtract must be taken
   // even though the 32-bit ALU compare reports a borrow.
   assign take      = !alu_less || acc_q[XLEN-1];

`ifdef MULDIV_EARLY_OUT_EN
   // Leave after the iteration that consumes the last set multiplier bit.
   assign run_exit  = last_iter || (!is_div_q && (opb_q[XLEN-1:1] == '0));
`else
   assign run_exit  = last_iter;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (op_div && (src_b == '0)) begin
                  state_d = FIN;
`ifdef MULDIV_EARLY_OUT_EN
               end else if (op_mul && (src_b == '0)) begin
                  state_d = FIN;
`endif
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN:     if (run_exit) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      alu_ctr = ALU_ADD;
      unique case (state_q)
         RUN: begin
            busy = 1'b1;
            if (is_div_q) begin
               alu_a   = rem_sh;
               alu_b   = opb_q;
               alu_ctr = ALU_SUB;
            end else begin
               alu_a   = acc_q;
               alu_b   = sh_q;
               alu_ctr = ALU_ADD;
            end
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      acc_d = acc_q;
      sh_d  = sh_q;
      opb_d = opb_q;
      if (is_div_q) begin
         acc_d = take ? alu_res : rem_sh;
         sh_d  = {sh_q[XLEN-2:0], take};
      end else begin
         acc_d = opb_q[0] ? alu_res : acc_q;
         sh_d  = sh_q << 1;
         opb_d = opb_q >> 1;
      end
   end

   always_comb begin
      result_d = result_q;
      if (accept && (state_d == FIN)) begin
         // Divide by zero (or zero multiplier with early-out): no iterations run.
         if (op_rem)      result_d = src_a;
         else if (op_div) result_d = '1;
         else             result_d = '0;
      end else if ((state_q == RUN) && (state_d == FIN)) begin
         if (!is_div_q)     result_d = acc_d;
         else if (is_rem_q) result_d = acc_d;
         else               result_d = sh_d;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         is_rem_q <= 1'b0;
         acc_q    <= '0;
         sh_q     <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else begin
         result_q <= result_d;
         if (accept) begin
            cnt_q    <= '0;
            is_div_q <= op_div;
            is_rem_q <= op_rem;
            acc_q    <= '0;
            sh_q     <= src_a;
            opb_q    <= src_b;
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= acc_d;
            sh_q  <= sh_d;
            opb_q <= opb_d;
         end
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed self-checking bench for alu_muldiv_seq with a behavioural ALU
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] result;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_ctr;
   logic [31:0] alu_res;
   logic        alu_less;

   int checks;
   int errors;

   int lat, ctr_bad, busy_bad;
   logic [31:0] held;

   alu_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ctr  (alu_ctr),
      .alu_res  (alu_res),
      .alu_less (alu_less)
   );

   // Shared ALU as the parent would provide it.
   always_comb begin
      alu_res  = alu_ctr[3] ? (alu_a - alu_b) : (alu_a + alu_b);
      alu_less = (alu_a < alu_b);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request and watch it to done. Latency counts edges from the accept
   // edge inclusive; stops at the negedge where done is seen (or after 40 edges).
   // inj > 0: at that RUN cycle a new start with other operands is pulsed.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int l, output int cbad, output int bbad);
      logic [3:0] exp_ctr;
      exp_ctr = ((o == MD_DIVU) || (o == MD_REMU)) ? ALU_SUB : ALU_ADD;
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l = 0; cbad = 0; bbad = 0;
      for (int n = 1; n <= 40; n++) begin
         if (done) begin
            l = n;
            if (busy) bbad++;
            break;
         end
         if (!busy) bbad++;
         if (alu_ctr !== exp_ctr) cbad++;
         if (n == inj) begin
            start = 1'b1; op = MD_MUL; src_a = 32'd3; src_b = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      #12;
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_done",    {31'd0, done}, 32'd0);
      check("rst_result",  result, 32'd0);
      check("rst_alu_a",   alu_a, 32'd0);
      check("rst_alu_b",   alu_b, 32'd0);
      check("rst_alu_ctr", {28'd0, alu_ctr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // MUL 7 x 6
      run_op(MD_MUL, 32'd7, 32'd6, 0, lat, ctr_bad, busy_bad);
      check("mul7x6_lat", lat, 32'd33);
      check("mul7x6_res", result, 32'd42);
      check("mul7x6_ctr", ctr_bad, 32'd0);
      check("mul7x6_busy", busy_bad, 32'd0);
      held = result;
      @(negedge clk);
      check("mul_done_drop", {31'd0, done}, 32'd0);
      check("mul_res_hold",  result, held);
      check("idle_alu_a",    alu_a, 32'd0);

      // MUL all-ones: (-1)*(-1) low word = 1
      run_op(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, ctr_bad, busy_bad);
      check("mul_ff_res", result, 32'h0000_0001);

      // MUL 0x12345678 x 0x10 = 0x23456780
      run_op(MD_MUL, 32'h1234_5678, 32'h0000_0010, 0, lat, ctr_bad, busy_bad);
      check("mul_shift_res", result, 32'h2345_6780);

      // DIVU / REMU 100 / 7
      run_op(MD_DIVU, 32'd100, 32'd7, 0, lat, ctr_bad, busy_bad);
      check("divu_lat", lat, 32'd33);
      check("divu_res", result, 32'd14);
      check("divu_ctr", ctr_bad, 32'd0);
      run_op(MD_REMU, 32'd100, 32'd7, 0, lat, ctr_bad, busy_bad);
      check("remu_res", result, 32'd2);
      check("remu_ctr", ctr_bad, 32'd0);

      // Large divisor and dividend: 0xFFFFFFFF / 0x80000001 = 1 rem 0x7FFFFFFE
      run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0, lat, ctr_bad, busy_bad);
      check("divu_big_res", result, 32'd1);
      run_op(MD_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 0, lat, ctr_bad, busy_bad);
      check("remu_big_res", result, 32'h7FFF_FFFE);

      // Divide by zero
      run_op(MD_DIVU, 32'd5, 32'd0, 0, lat, ctr_bad, busy_bad);
      check("div0_lat",  lat, 32'd1);
      check("div0_res",  result, 32'hFFFF_FFFF);
      check("div0_busy", busy_bad, 32'd0);
      run_op(MD_REMU, 32'd5, 32'd0, 0, lat, ctr_bad, busy_bad);
      check("rem0_lat",  lat, 32'd1);
      check("rem0_res",  result, 32'd5);

      // start in RUN is ignored
      run_op(MD_MUL, 32'd7, 32'd6, 10, lat, ctr_bad, busy_bad);
      check("ign_lat", lat, 32'd33);
      check("ign_res", result, 32'd42);
      @(negedge clk);
      check("ign_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-run (result is 42 going in)
      @(negedge clk);
      op = MD_MUL; src_a = 32'd11; src_b = 32'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",   {31'd0, busy}, 32'd0);
      check("arst_done",   {31'd0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MD_DIVU, 32'd100, 32'd7, 0, lat, ctr_bad, busy_bad);
      check("post_rst_lat", lat, 32'd33);
      check("post_rst_res", result, 32'd14);

      // Multiplier 3 (early-out build exits after its top set bit)
      run_op(MD_MUL, 32'd9, 32'd3, 0, lat, ctr_bad, busy_bad);
      check("mul9x3_res", result, 32'd27);
`ifdef MULDIV_EARLY_OUT_EN
      check("mul9x3_lat", lat, 32'd3);
      run_op(MD_MUL, 32'd9, 32'd0, 0, lat, ctr_bad, busy_bad);
      check("mul_x0_lat", lat, 32'd1);
      check("mul_x0_res", result, 32'd0);
`else
      check("mul9x3_lat", lat, 32'd33);
      run_op(MD_MUL, 32'd9, 32'd0, 0, lat, ctr_bad, busy_bad);
      check("mul_x0_lat", lat, 32'd33);
      check("mul_x0_res", result, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
